// File: rtl/dmem_debug_master.sv
// Debug/boot bus initiator for the data-memory interface: accepts one burst
// command, then streams words into (write) or out of (read) DMemory_IO.
module dmem_debug_master #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int LW        = 8,
    parameter int ADDR_STEP = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          abort,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] dmemaddr,
    output logic [DW-1:0] dmemwdata,
    output logic          dmemwrite,
    output logic          dmemread,
    input  logic [DW-1:0] dmemrdata,
    output logic          cpu_hold,
    output logic          done
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_WAIT   = 3'd1;
    localparam logic [2:0] WR_STROBE = 3'd2;
    localparam logic [2:0] RD_STROBE = 3'd3;
    localparam logic [2:0] RD_HOLD   = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [AW-1:0] addr;
    logic [LW-1:0] cnt;
    logic          cmd_fire;
    logic          last_word;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign last_word = (cnt == LW'(1));
    // The address register doubles as the bus address; it only moves after a strobe.
    assign dmemaddr  = addr;

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_len == '0)  next_state = DONE;
                    else if (cmd_write) next_state = WR_WAIT;
                    else                next_state = RD_STROBE;
                end
            end
            WR_WAIT: begin
                if (abort)         next_state = IDLE;
                else if (wr_valid) next_state = WR_STROBE;
            end
            WR_STROBE: begin
                if (abort)          next_state = IDLE;
                else if (last_word) next_state = DONE;
                else                next_state = WR_WAIT;
            end
            RD_STROBE: next_state = abort ? IDLE : RD_HOLD;
            RD_HOLD: begin
                if (abort)         next_state = IDLE;
                else if (rd_ready) next_state = last_word ? DONE : RD_STROBE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            dmemwdata <= '0;
            rd_data   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        addr <= cmd_addr;
                        cnt  <= cmd_len;
                    end
                end
                WR_WAIT: begin
                    if (!abort && wr_valid) dmemwdata <= wr_data;
                end
                WR_STROBE: begin
                    addr <= addr + STEP;
                    cnt  <= cnt - LW'(1);
                end
                RD_STROBE: rd_data <= dmemrdata;
                RD_HOLD: begin
                    if (!abort && rd_ready) begin
                        addr <= addr + STEP;
                        cnt  <= cnt - LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control outputs are flops decoded from next_state, so they line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_ready <= 1'b1;
            cpu_hold  <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            dmemwrite <= 1'b0;
            dmemread  <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmd_ready <= (next_state == IDLE);
            cpu_hold  <= (next_state != IDLE);
            wr_ready  <= (next_state == WR_WAIT);
            rd_valid  <= (next_state == RD_HOLD);
            dmemwrite <= (next_state == WR_STROBE);
            dmemread  <= (next_state == RD_STROBE);
            done      <= (next_state == DONE);
        end
    end

endmodule
